// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
package tri_bus_arbiter_pkg;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant/drive bundle between the requesters and the arbiter.
interface tri_bus_arbiter_if
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       grant;
  logic [N-1:0]       drv_en;
  logic [WIDTH-1:0]   drv_data;
  logic               busy;

  // Arbiter side: consumes requests, produces grants and enables.
  modport master (
    input  req,
    input  din,
    output grant,
    output drv_en,
    output drv_data,
    output busy
  );

  // Requester side: the mirror image.
  modport slave (
    output req,
    output din,
    input  grant,
    input  drv_en,
    input  drv_data,
    input  busy
  );
endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving one-hot tristate enables with a turnaround gap
// between owners, plus the N tristate buffers onto the shared bus net.
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_bus_arbiter_if.master bus,
  output wire [WIDTH-1:0]   bus_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t            state_q;
  logic [PW-1:0]     owner_q;
  logic [PW-1:0]     ptr_q;
  logic [HW-1:0]     hold_cnt_q;
  logic [N-1:0]      grant_q;
  logic [N-1:0]      drv_en_q;
  logic [WIDTH-1:0]  drv_data_q;
  logic              busy_q;

  logic [WIDTH-1:0]  owner_din;
  logic [PW-1:0]     ptr_after_owner;
  logic [PW-1:0]     pick_ptr;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic [N-1:0]      pick_oh;
  logic              release_now;

  // Select the current owner's data slice and the pointer the picker searches from.
  always_comb begin
    owner_din = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) owner_din = bus.din[i*WIDTH +: WIDTH];
    end
    ptr_after_owner = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
    // On a DRIVE exit the next owner is searched from just past the current one.
    pick_ptr    = (state_q == S_DRIVE) ? ptr_after_owner : ptr_q;
    release_now = !bus.req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD - 1));
  end

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      drv_en_q   <= '0;
      drv_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          drv_en_q   <= '0;
          drv_data_q <= '0;
          hold_cnt_q <= '0;
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= pick_oh;
            state_q <= S_TURN;
            busy_q  <= 1'b1;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_TURN: begin
          // Enables were off for this whole cycle; the new owner drives next.
          drv_en_q   <= grant_q;
          drv_data_q <= owner_din;
          hold_cnt_q <= '0;
          state_q    <= S_DRIVE;
          busy_q     <= 1'b1;
        end
        S_DRIVE: begin
          if (release_now) begin
            ptr_q      <= ptr_after_owner;
            drv_en_q   <= '0;
            hold_cnt_q <= '0;
            if (pick_valid) begin
              owner_q    <= pick_idx;
              grant_q    <= pick_oh;
              drv_data_q <= owner_din;
              state_q    <= S_TURN;
              busy_q     <= 1'b1;
            end else begin
              grant_q    <= '0;
              drv_data_q <= '0;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
            end
          end else begin
            drv_data_q <= owner_din;
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          grant_q    <= '0;
          drv_en_q   <= '0;
          drv_data_q <= '0;
          hold_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.drv_en   = drv_en_q;
  assign bus.drv_data = drv_data_q;
  assign bus.busy     = busy_q;

  // Tristate buffers: each enabled by its own drv_en bit, all onto one net.
  for (genvar i = 0; i < N; i++) begin : g_buf
    assign bus_o = drv_en_q[i] ? drv_data_q : {WIDTH{1'bz}};
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed and randomized bench for tri_bus_arbiter.
module tb_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire [W-1:0] bus_w;
  int checks = 0;
  int failures = 0;

  tri_bus_arbiter_if #(.N(N), .WIDTH(W)) bif ();

  tri_bus_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .bus_o (bus_w)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bif.req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.req = 4'b1111;
    bif.din = 16'h4321;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bif.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bif.grant); end
    checks++; if (bif.drv_en !== 4'b0000) begin failures++; $display("FAIL reset_drv_en got=%b exp=0000", bif.drv_en); end
    checks++; if (bif.drv_data !== 4'h0) begin failures++; $display("FAIL reset_drv_data got=%h exp=0", bif.drv_data); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (bif.grant !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", bif.grant); end
    checks++; if (bif.drv_en !== 4'b0000) begin failures++; $display("FAIL reset_turn_gap got=%b exp=0000", bif.drv_en); end
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_turn got=%b exp=1", bif.busy); end
    tick();
    checks++; if (bif.drv_en !== 4'b0001) begin failures++; $display("FAIL reset_first_drive got=%b exp=0001", bif.drv_en); end
    checks++; if (bif.drv_data !== 4'h1) begin failures++; $display("FAIL reset_first_data got=%h exp=1", bif.drv_data); end
    bif.req = 4'b0000;
    tick();
    checks++; if (bif.drv_en !== 4'b0000 || bif.grant !== 4'b0000 || bif.busy !== 1'b0) begin
      failures++; $display("FAIL reset_release en=%b grant=%b busy=%b exp=0000/0000/0", bif.drv_en, bif.grant, bif.busy);
    end
  endtask

  task automatic test_single_grant();
    bif.din = 16'h0A00;
    bif.req = 4'b0100;
    tick();
    checks++; if (bif.grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", bif.grant); end
    checks++; if (bif.drv_en !== 4'b0000) begin failures++; $display("FAIL single_turn got=%b exp=0000", bif.drv_en); end
    tick();
    checks++; if (bif.drv_en !== 4'b0100) begin failures++; $display("FAIL single_drive got=%b exp=0100", bif.drv_en); end
    checks++; if (bif.drv_data !== 4'hA) begin failures++; $display("FAIL single_data got=%h exp=a", bif.drv_data); end
    bif.din = 16'h0500;
    tick();
    checks++; if (bif.drv_data !== 4'h5) begin failures++; $display("FAIL single_data_latency got=%h exp=5", bif.drv_data); end
    tick();
    checks++; if (bif.drv_en !== 4'b0100) begin failures++; $display("FAIL single_hold3 got=%b exp=0100", bif.drv_en); end
    bif.req = 4'b0000;
    tick();
    checks++; if (bif.drv_en !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", bif.drv_en); end
    checks++; if (bif.busy !== 1'b0 || bif.grant !== 4'b0000) begin
      failures++; $display("FAIL single_idle busy=%b grant=%b exp=0/0000", bif.busy, bif.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] dv;
    int o;
    do_reset();
    dv = 16'hDCBA;
    bif.din = dv;
    bif.req = 4'b1111;
    tick();
    checks++; if (bif.grant !== 4'b0001 || bif.drv_en !== 4'b0000) begin
      failures++; $display("FAIL rr_first_turn grant=%b en=%b exp=0001/0000", bif.grant, bif.drv_en);
    end
    for (int s = 0; s < 5; s++) begin
      o = s % 4;
      for (int c = 0; c < MH; c++) begin
        tick();
        checks++; if (bif.drv_en !== (4'b0001 << o) || bif.drv_data !== dv[o*4 +: 4]) begin
          failures++; $display("FAIL rr_drive owner=%0d cyc=%0d en=%b data=%h exp=%b/%h", o, c, bif.drv_en, bif.drv_data, 4'b0001 << o, dv[o*4 +: 4]);
        end
      end
      if (s < 4) begin
        tick();
        checks++; if (bif.drv_en !== 4'b0000 || bif.grant !== (4'b0001 << ((s + 1) % 4))) begin
          failures++; $display("FAIL rr_gap after=%0d en=%b grant=%b exp=0000/%b", o, bif.drv_en, bif.grant, 4'b0001 << ((s + 1) % 4));
        end
      end
    end
    bif.req = 4'b0000;
    tick();
    checks++; if (bif.busy !== 1'b0 || bif.drv_en !== 4'b0000) begin
      failures++; $display("FAIL rr_end busy=%b en=%b exp=0/0000", bif.busy, bif.drv_en);
    end
  endtask

  task automatic test_forced_release();
    logic [3:0] exp_en;
    do_reset();
    bif.req = 4'b0001;
    tick();
    checks++; if (bif.grant !== 4'b0001 || bif.busy !== 1'b1) begin
      failures++; $display("FAIL hold_turn grant=%b busy=%b exp=0001/1", bif.grant, bif.busy);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_en = ((c % 9) < 8) ? 4'b0001 : 4'b0000;
      checks++; if (bif.drv_en !== exp_en || bif.busy !== 1'b1) begin
        failures++; $display("FAIL hold_pattern cyc=%0d en=%b busy=%b exp=%b/1", c, bif.drv_en, bif.busy, exp_en);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0]  prev_en;
    logic [15:0] dv;
    int idx;
    do_reset();
    prev_en = 4'b0000;
    bif.req = 4'b0000;
    bif.din = 16'h0000;
    for (int c = 0; c < 2000; c++) begin
      tick();
      dv = bif.din;
      checks++; if ($countones(bif.drv_en) > 1 || $countones(bif.grant) > 1) begin
        failures++; $display("FAIL rand_onehot cyc=%0d en=%b grant=%b", c, bif.drv_en, bif.grant);
      end
      checks++; if (prev_en != 4'b0000 && bif.drv_en != 4'b0000 && bif.drv_en !== prev_en) begin
        failures++; $display("FAIL rand_no_gap cyc=%0d en=%b prev=%b", c, bif.drv_en, prev_en);
      end
      if (bif.drv_en != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (bif.drv_en[i]) idx = i;
        checks++; if (bif.drv_data !== dv[idx*4 +: 4] || bif.grant !== bif.drv_en) begin
          failures++; $display("FAIL rand_data cyc=%0d data=%h grant=%b exp=%h/%b", c, bif.drv_data, bif.grant, dv[idx*4 +: 4], bif.drv_en);
        end
      end
      prev_en = bif.drv_en;
      if ($urandom_range(0, 3) == 0) bif.req = 4'($urandom_range(0, 15));
      bif.din = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    bif.din = 16'h3C5A;
    bif.req = 4'b0100;
    tick();
    tick();
    tick();
    checks++; if (bif.drv_en !== 4'b0100) begin failures++; $display("FAIL mid_drive_owner2 got=%b exp=0100", bif.drv_en); end
    rst_n = 1'b0;
    bif.req = 4'b1010;
    tick();
    checks++; if (bif.drv_en !== 4'b0000 || bif.grant !== 4'b0000 || bif.drv_data !== 4'h0 || bif.busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs en=%b grant=%b data=%h busy=%b exp=0", bif.drv_en, bif.grant, bif.drv_data, bif.busy);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (bif.grant !== 4'b0010 || bif.drv_en !== 4'b0000) begin
      failures++; $display("FAIL mid_regrant grant=%b en=%b exp=0010/0000", bif.grant, bif.drv_en);
    end
    tick();
    checks++; if (bif.drv_en !== 4'b0010 || bif.drv_data !== 4'h5) begin
      failures++; $display("FAIL mid_drive1 en=%b data=%h exp=0010/5", bif.drv_en, bif.drv_data);
    end
  endtask

  initial begin
    bif.req = '0;
    bif.din = '0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_forced_release();
    test_random();
    test_reset_mid_drive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
